// File: rtl/imem_pkg.sv
// Shared types and constants for the Wishbone instruction-fetch bridge.
package imem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // At least 8 bits; wider only when the timeout limit needs it.
  function automatic int timeout_width(input int timeout);
    return ($clog2(timeout + 1) > 8) ? $clog2(timeout + 1) : 8;
  endfunction

endpackage

// File: rtl/imem_wb_bridge_if.sv
// Wishbone B4 pipelined read-only bus between the fetch bridge (master) and memory (slave).
interface imem_wb_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  wb_cyc;
  logic                  wb_stb;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic                  wb_stall;
  logic                  wb_ack;
  logic                  wb_err;
  logic [31:0]           wb_rd_data;

  modport master (
    output wb_cyc, wb_stb, wb_addr,
    input  wb_stall, wb_ack, wb_err, wb_rd_data
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_addr,
    output wb_stall, wb_ack, wb_err, wb_rd_data
  );
endinterface

// File: rtl/imem_wb_timeout.sv
// Saturating wait counter for an accepted strobe; flags expiry at WB_TIMEOUT (0 disables).
module imem_wb_timeout
  import imem_pkg::*;
#(
  parameter int WB_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int            W     = timeout_width(WB_TIMEOUT);
  localparam logic [W-1:0]  LIMIT = W'(WB_TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= '0;
    else if (en && (count != '1))
      count <= count + W'(1);
  end

  assign expired = (WB_TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/imem_wb_bridge.sv
// Fetch-port responder issuing single pipelined Wishbone reads; optional hit buffer
// is enabled by defining IMEM_HIT_BUF_EN.
module imem_wb_bridge
  import imem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    WB_TIMEOUT = 255,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_req,
  output logic [31:0]           instr,
  output logic                  instr_ack,
  output logic                  instr_err,
  input  logic                  fence_i,
  imem_wb_bridge_if.master      wb
);

  state_t                state, state_nxt;
  logic                  cyc_d, stb_d, ack_d, err_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           instr_d;
  logic                  aligned, accepted, expired, bus_done, bus_fail;
  logic                  hit;
  logic [31:0]           hit_data;

  assign aligned  = (instr_addr[1:0] & ALIGN_MASK) == 2'b00;
  assign accepted = wb.wb_stb && !wb.wb_stall;
  assign bus_done = wb.wb_ack || wb.wb_err || expired;
  // A real ack beats a coincident timeout; an error beats everything.
  assign bus_fail = wb.wb_err || (expired && !wb.wb_ack);

  imem_wb_timeout #(.WB_TIMEOUT(WB_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    ((state != WAIT) && (state != DRAIN)),
    .en      ((state == WAIT) || (state == DRAIN)),
    .expired (expired)
  );

`ifdef IMEM_HIT_BUF_EN
  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [31:0]           buf_data;
  logic                  fill;

  assign hit      = buf_valid && !fence_i && (buf_addr == instr_addr);
  assign hit_data = buf_data;
  assign fill     = (state == WAIT) && instr_req && wb.wb_ack && !wb.wb_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (fence_i) begin
      buf_valid <= 1'b0;
    end else if (fill) begin
      buf_valid <= 1'b1;
      buf_addr  <= wb.wb_addr;
      buf_data  <= wb.wb_rd_data;
    end
  end
`else
  logic unused_fence;
  assign unused_fence = fence_i;
  assign hit          = 1'b0;
  assign hit_data     = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wb.wb_cyc <= 1'b0;
      wb.wb_stb <= 1'b0;
      wb.wb_addr <= PC_RESET;
      instr_ack <= 1'b0;
      instr_err <= 1'b0;
      instr     <= '0;
    end else begin
      state     <= state_nxt;
      wb.wb_cyc <= cyc_d;
      wb.wb_stb <= stb_d;
      wb.wb_addr <= addr_d;
      instr_ack <= ack_d;
      instr_err <= err_d;
      instr     <= instr_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (instr_req && aligned && !hit) state_nxt = REQ;
      REQ:   if (accepted)        state_nxt = instr_req ? WAIT : DRAIN;
             else if (!instr_req) state_nxt = IDLE;
      WAIT:  if (bus_done)        state_nxt = IDLE;
             else if (!instr_req) state_nxt = DRAIN;
      DRAIN: if (bus_done)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; a draining response is swallowed.
  always_comb begin
    cyc_d   = wb.wb_cyc;
    stb_d   = wb.wb_stb;
    addr_d  = wb.wb_addr;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    instr_d = '0;
    case (state)
      IDLE: begin
        if (instr_req) begin
          if (!aligned) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else if (hit) begin
            ack_d   = 1'b1;
            instr_d = hit_data;
          end else begin
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            addr_d = instr_addr;
          end
        end
      end
      REQ: begin
        if (accepted) begin
          stb_d = 1'b0;
        end else if (!instr_req) begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
        end
      end
      WAIT: begin
        if (bus_done) begin
          cyc_d = 1'b0;
          if (instr_req) begin
            ack_d   = 1'b1;
            err_d   = bus_fail;
            instr_d = bus_fail ? 32'h0 : wb.wb_rd_data;
          end
        end
      end
      DRAIN: begin
        if (bus_done) cyc_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_imem_wb_bridge.sv
// Directed bench for imem_wb_bridge: table of per-cycle vectors plus hand-built corner sequences.
module tb_imem_wb_bridge;
  import imem_pkg::*;

  localparam logic [31:0] PC_RST = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic [31:0] instr;
  logic        instr_ack;
  logic        instr_err;
  logic        fence_i;

  int assertions = 0;
  int failures   = 0;

  imem_wb_bridge_if #(.ADDR_WIDTH(32)) wb ();

  imem_wb_bridge #(
    .ADDR_WIDTH (32),
    .WB_TIMEOUT (8),
    .PC_RESET   (PC_RST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_addr (instr_addr),
    .instr_req  (instr_req),
    .instr      (instr),
    .instr_ack  (instr_ack),
    .instr_err  (instr_err),
    .fence_i    (fence_i),
    .wb         (wb)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        req;
    logic [31:0] addr;
    logic        fence;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        e_cyc;
    logic        e_stb;
    logic [31:0] e_addr;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(string n, logic req, logic [31:0] a, logic st, logic ak,
                              logic er, logic [31:0] rd, logic ec, logic es,
                              logic [31:0] ea, logic eak, logic eer, logic [31:0] ei);
    vec_t v;
    v.name = n;   v.req = req;  v.addr = a;   v.fence = 1'b0;
    v.stall = st; v.ack = ak;   v.err = er;   v.rdata = rd;
    v.e_cyc = ec; v.e_stb = es; v.e_addr = ea;
    v.e_ack = eak; v.e_err = eer; v.e_instr = ei;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    instr_req      = v.req;
    instr_addr     = v.addr;
    fence_i        = v.fence;
    wb.wb_stall    = v.stall;
    wb.wb_ack      = v.ack;
    wb.wb_err      = v.err;
    wb.wb_rd_data  = v.rdata;
  endtask

  task automatic checkOutput(input vec_t v);
    assertions++;
    if (wb.wb_cyc !== v.e_cyc || wb.wb_stb !== v.e_stb || wb.wb_addr !== v.e_addr ||
        instr_ack !== v.e_ack || instr_err !== v.e_err || instr !== v.e_instr) begin
      failures++;
      $display("[TB] FAIL %s: got cyc=%b stb=%b addr=%h ack=%b err=%b instr=%h, expected cyc=%b stb=%b addr=%h ack=%b err=%b instr=%h",
               v.name, wb.wb_cyc, wb.wb_stb, wb.wb_addr, instr_ack, instr_err, instr,
               v.e_cyc, v.e_stb, v.e_addr, v.e_ack, v.e_err, v.e_instr);
    end
  endtask

  // Inputs hold for one cycle; outputs registered at that edge are checked 1 time unit later.
  task automatic step(input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(v);
  endtask

  // The fetch side may only change the address while requesting in the ack cycle.
  initial begin : addr_monitor
    logic        last_req;
    logic [31:0] last_addr;
    last_req  = 1'b0;
    last_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst && instr_req && last_req && !instr_ack && instr_addr !== last_addr) begin
        failures++;
        $display("[TB] FAIL addr_stable: instr_addr changed to %h while request for %h pending",
                 instr_addr, last_addr);
      end
      last_req  = instr_req;
      last_addr = instr_addr;
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t vecs[$];
    vec_t v;

    // Each entry: inputs for one cycle, then outputs expected after that edge.
    // Zero-wait slave, addr 0x10.
    vecs.push_back(mk("zw_req",  1, 32'h10, 0, 0, 0, 32'h0,        1, 1, 32'h10, 0, 0, 32'h0));
    vecs.push_back(mk("zw_acc",  1, 32'h10, 0, 0, 0, 32'h0,        1, 0, 32'h10, 0, 0, 32'h0));
    vecs.push_back(mk("zw_ack",  1, 32'h10, 0, 1, 0, 32'h00500093, 0, 0, 32'h10, 1, 0, 32'h00500093));
    vecs.push_back(mk("zw_idle", 0, 32'h10, 0, 0, 0, 32'h0,        0, 0, 32'h10, 0, 0, 32'h0));
    // Stall held three cycles on 0x18.
    vecs.push_back(mk("st_req",  1, 32'h18, 0, 0, 0, 32'h0,        1, 1, 32'h18, 0, 0, 32'h0));
    vecs.push_back(mk("st_s1",   1, 32'h18, 1, 0, 0, 32'h0,        1, 1, 32'h18, 0, 0, 32'h0));
    vecs.push_back(mk("st_s2",   1, 32'h18, 1, 0, 0, 32'h0,        1, 1, 32'h18, 0, 0, 32'h0));
    vecs.push_back(mk("st_s3",   1, 32'h18, 1, 0, 0, 32'h0,        1, 1, 32'h18, 0, 0, 32'h0));
    vecs.push_back(mk("st_acc",  1, 32'h18, 0, 0, 0, 32'h0,        1, 0, 32'h18, 0, 0, 32'h0));
    vecs.push_back(mk("st_ack",  1, 32'h18, 0, 1, 0, 32'h00A00113, 0, 0, 32'h18, 1, 0, 32'h00A00113));
    vecs.push_back(mk("st_idle", 0, 32'h18, 0, 0, 0, 32'h0,        0, 0, 32'h18, 0, 0, 32'h0));
    // Misaligned request: immediate error, no bus cycle.
    vecs.push_back(mk("mis_req", 1, 32'h0A, 0, 0, 0, 32'h0,        0, 0, 32'h18, 1, 1, 32'h0));
    vecs.push_back(mk("mis_idle",0, 32'h0A, 0, 0, 0, 32'h0,        0, 0, 32'h18, 0, 0, 32'h0));
    // Abort while the strobe is still stalled.
    vecs.push_back(mk("ab_req",  1, 32'h28, 0, 0, 0, 32'h0,        1, 1, 32'h28, 0, 0, 32'h0));
    vecs.push_back(mk("ab_drop", 0, 32'h28, 1, 0, 0, 32'h0,        0, 0, 32'h28, 0, 0, 32'h0));
    vecs.push_back(mk("ab_idle", 0, 32'h28, 0, 0, 0, 32'h0,        0, 0, 32'h28, 0, 0, 32'h0));
    // Bus error one cycle into the wait.
    vecs.push_back(mk("er_req",  1, 32'h40, 0, 0, 0, 32'h0,        1, 1, 32'h40, 0, 0, 32'h0));
    vecs.push_back(mk("er_acc",  1, 32'h40, 0, 0, 0, 32'h0,        1, 0, 32'h40, 0, 0, 32'h0));
    vecs.push_back(mk("er_wait", 1, 32'h40, 0, 0, 0, 32'h0,        1, 0, 32'h40, 0, 0, 32'h0));
    vecs.push_back(mk("er_err",  1, 32'h40, 0, 0, 1, 32'h0,        0, 0, 32'h40, 1, 1, 32'h0));
    vecs.push_back(mk("er_idle", 0, 32'h40, 0, 0, 0, 32'h0,        0, 0, 32'h40, 0, 0, 32'h0));
    // Ack and err together: error wins, data is dropped.
    vecs.push_back(mk("ae_req",  1, 32'h44, 0, 0, 0, 32'h0,        1, 1, 32'h44, 0, 0, 32'h0));
    vecs.push_back(mk("ae_acc",  1, 32'h44, 0, 0, 0, 32'h0,        1, 0, 32'h44, 0, 0, 32'h0));
    vecs.push_back(mk("ae_both", 1, 32'h44, 0, 1, 1, 32'hDEADBEEF, 0, 0, 32'h44, 1, 1, 32'h0));
    vecs.push_back(mk("ae_idle", 0, 32'h44, 0, 0, 0, 32'h0,        0, 0, 32'h44, 0, 0, 32'h0));
    // Back-to-back: next address presented in the ack cycle.
    vecs.push_back(mk("bb_req1", 1, 32'h04, 0, 0, 0, 32'h0,        1, 1, 32'h04, 0, 0, 32'h0));
    vecs.push_back(mk("bb_acc1", 1, 32'h04, 0, 0, 0, 32'h0,        1, 0, 32'h04, 0, 0, 32'h0));
    vecs.push_back(mk("bb_ack1", 1, 32'h04, 0, 1, 0, 32'h00100113, 0, 0, 32'h04, 1, 0, 32'h00100113));
    vecs.push_back(mk("bb_req2", 1, 32'h08, 0, 0, 0, 32'h0,        1, 1, 32'h08, 0, 0, 32'h0));
    vecs.push_back(mk("bb_acc2", 1, 32'h08, 0, 0, 0, 32'h0,        1, 0, 32'h08, 0, 0, 32'h0));
    vecs.push_back(mk("bb_ack2", 1, 32'h08, 0, 1, 0, 32'h00200193, 0, 0, 32'h08, 1, 0, 32'h00200193));
    vecs.push_back(mk("bb_idle", 0, 32'h08, 0, 0, 0, 32'h0,        0, 0, 32'h08, 0, 0, 32'h0));

    rst           = 1'b1;
    instr_req     = 1'b0;
    instr_addr    = '0;
    fence_i       = 1'b0;
    wb.wb_stall   = 1'b0;
    wb.wb_ack     = 1'b0;
    wb.wb_err     = 1'b0;
    wb.wb_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, PC_RST, 0, 0, 32'h0));
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Abort after acceptance; a new request during drain waits for the old response.
    step(mk("dr_req",    1, 32'h20, 0, 0, 0, 32'h0,        1, 1, 32'h20, 0, 0, 32'h0));
    step(mk("dr_acc",    1, 32'h20, 0, 0, 0, 32'h0,        1, 0, 32'h20, 0, 0, 32'h0));
    step(mk("dr_drop",   0, 32'h20, 0, 0, 0, 32'h0,        1, 0, 32'h20, 0, 0, 32'h0));
    step(mk("dr_newreq", 1, 32'h24, 0, 0, 0, 32'h0,        1, 0, 32'h20, 0, 0, 32'h0));
    step(mk("dr_ack",    1, 32'h24, 0, 1, 0, 32'h00300213, 0, 0, 32'h20, 0, 0, 32'h0));
    step(mk("dr_req2",   1, 32'h24, 0, 0, 0, 32'h0,        1, 1, 32'h24, 0, 0, 32'h0));
    step(mk("dr_acc2",   1, 32'h24, 0, 0, 0, 32'h0,        1, 0, 32'h24, 0, 0, 32'h0));
    step(mk("dr_ack2",   1, 32'h24, 0, 1, 0, 32'h00400293, 0, 0, 32'h24, 1, 0, 32'h00400293));
    step(mk("dr_idle",   0, 32'h24, 0, 0, 0, 32'h0,        0, 0, 32'h24, 0, 0, 32'h0));

    // Silent slave: the counter starts at 0 on the acceptance edge and expires on reaching 8.
    step(mk("to_req",  1, 32'h48, 0, 0, 0, 32'h0, 1, 1, 32'h48, 0, 0, 32'h0));
    step(mk("to_acc",  1, 32'h48, 0, 0, 0, 32'h0, 1, 0, 32'h48, 0, 0, 32'h0));
    for (int k = 0; k < 8; k++)
      step(mk("to_wait", 1, 32'h48, 0, 0, 0, 32'h0, 1, 0, 32'h48, 0, 0, 32'h0));
    step(mk("to_fire", 1, 32'h48, 0, 0, 0, 32'h0, 0, 0, 32'h48, 1, 1, 32'h0));
    step(mk("to_idle", 0, 32'h48, 0, 0, 0, 32'h0, 0, 0, 32'h48, 0, 0, 32'h0));

    // First fetch of 0x30 always uses the bus.
    step(mk("hb_req",  1, 32'h30, 0, 0, 0, 32'h0,        1, 1, 32'h30, 0, 0, 32'h0));
    step(mk("hb_acc",  1, 32'h30, 0, 0, 0, 32'h0,        1, 0, 32'h30, 0, 0, 32'h0));
    step(mk("hb_ack",  1, 32'h30, 0, 1, 0, 32'h00500313, 0, 0, 32'h30, 1, 0, 32'h00500313));
    step(mk("hb_idle", 0, 32'h30, 0, 0, 0, 32'h0,        0, 0, 32'h30, 0, 0, 32'h0));
`ifdef IMEM_HIT_BUF_EN
    step(mk("hb_hit",   1, 32'h30, 0, 0, 0, 32'h0,        0, 0, 32'h30, 1, 0, 32'h00500313));
    step(mk("hb_idle2", 0, 32'h30, 0, 0, 0, 32'h0,        0, 0, 32'h30, 0, 0, 32'h0));
    v = mk("hb_fence",  0, 32'h30, 0, 0, 0, 32'h0,        0, 0, 32'h30, 0, 0, 32'h0);
    v.fence = 1'b1;
    step(v);
    step(mk("hb_miss",  1, 32'h30, 0, 0, 0, 32'h0,        1, 1, 32'h30, 0, 0, 32'h0));
    step(mk("hb_acc2",  1, 32'h30, 0, 0, 0, 32'h0,        1, 0, 32'h30, 0, 0, 32'h0));
    step(mk("hb_ack2",  1, 32'h30, 0, 1, 0, 32'h00500313, 0, 0, 32'h30, 1, 0, 32'h00500313));
    step(mk("hb_idle3", 0, 32'h30, 0, 0, 0, 32'h0,        0, 0, 32'h30, 0, 0, 32'h0));
    v = mk("hb_fhit",   1, 32'h30, 0, 0, 0, 32'h0,        1, 1, 32'h30, 0, 0, 32'h0);
    v.fence = 1'b1;
    step(v);
    step(mk("hb_facc",  1, 32'h30, 0, 0, 0, 32'h0,        1, 0, 32'h30, 0, 0, 32'h0));
    step(mk("hb_fack",  1, 32'h30, 0, 1, 0, 32'h00500313, 0, 0, 32'h30, 1, 0, 32'h00500313));
    step(mk("hb_idle4", 0, 32'h30, 0, 0, 0, 32'h0,        0, 0, 32'h30, 0, 0, 32'h0));
`else
    step(mk("nb_req",   1, 32'h30, 0, 0, 0, 32'h0,        1, 1, 32'h30, 0, 0, 32'h0));
    step(mk("nb_acc",   1, 32'h30, 0, 0, 0, 32'h0,        1, 0, 32'h30, 0, 0, 32'h0));
    step(mk("nb_ack",   1, 32'h30, 0, 1, 0, 32'h00500313, 0, 0, 32'h30, 1, 0, 32'h00500313));
    step(mk("nb_idle",  0, 32'h30, 0, 0, 0, 32'h0,        0, 0, 32'h30, 0, 0, 32'h0));
`endif

    // Asynchronous reset in the middle of a strobe drops the cycle without an ack.
    step(mk("rs_req", 1, 32'h50, 0, 0, 0, 32'h0, 1, 1, 32'h50, 0, 0, 32'h0));
    rst = 1'b1;
    #2;
    checkOutput(mk("rs_async", 1, 32'h50, 0, 0, 0, 32'h0, 0, 0, PC_RST, 0, 0, 32'h0));
    instr_req = 1'b0;
    rst       = 1'b0;
    step(mk("rs_idle", 0, 32'h50, 0, 0, 0, 32'h0, 0, 0, PC_RST, 0, 0, 32'h0));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/imem_wb_bridge.md
Name: imem_wb_bridge

Overview:
Responder end of the fetch-stage instruction port (instr_addr / instr_req / instr / instr_ack). Turns each fetch request into a single pipelined Wishbone B4 read on a shared memory bus and returns the word to fetch with a one-cycle ack. Sits between the fetch stage and the bus interconnect, in place of a direct main_memory instruction port. Handles fetch aborts on flush or PC change, bus errors, and a bus timeout.

Parameters:
ADDR_WIDTH, 32, width of instr_addr and wb_addr
WB_TIMEOUT, 255, cycles to wait for wb_ack/wb_err after the strobe is accepted; 0 disables the timeout
PC_RESET, 0, address driven on wb_addr out of reset

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
instr_addr  in  ADDR_WIDTH  fetch address, stable while instr_req=1 until ack
instr_req  in  1  fetch request (level)
instr  out  32  fetched word, valid when instr_ack=1
instr_ack  out  1  one-cycle response pulse
instr_err  out  1  qualifies instr_ack: misaligned, bus error or timeout
fence_i  in  1  invalidates the hit buffer (optional feature); ignored otherwise
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_addr  out  ADDR_WIDTH  Wishbone address
wb_stall  in  1  slave not accepting strobe
wb_ack  in  1  read data valid
wb_err  in  1  bus error
wb_rd_data  in  32  read data

Behaviour:
- Reset (async): state IDLE; wb_cyc, wb_stb, instr_ack, instr_err = 0; instr = 0; wb_addr = PC_RESET; timeout counter = 0. Reset mid-transaction drops cyc immediately; no ack is issued.
- All outputs are registered. wb_we is implicitly 0 (read-only master).
- IDLE:
  - instr_req=1 and instr_addr[1:0]!=0: next cycle instr_ack=1, instr_err=1, instr=0, no bus cycle.
  - instr_req=1 and aligned: next cycle wb_cyc=1, wb_stb=1, wb_addr=instr_addr; go to REQ.
- REQ: hold stb/addr while wb_stall=1. Strobe accepted on the edge where stb=1 and stall=0; drop stb the next cycle, keep cyc; go to WAIT.
- WAIT: timeout counter increments each cycle.
  - wb_ack: drop cyc; next cycle instr=wb_rd_data, instr_ack=1, instr_err=0; go to IDLE.
  - wb_err, or counter==WB_TIMEOUT (if nonzero): drop cyc; instr_ack=1, instr_err=1, instr=0; go to IDLE.
- RESP (folded into IDLE): ack is exactly one cycle. A new request seen in the ack cycle starts its strobe the following cycle.
- Minimum latency: req at cycle 0, stb at cycle 1, slave ack at cycle 2, instr_ack at cycle 3.
- Abort: instr_req falls before ack.
  - In REQ with strobe not yet accepted: drop cyc/stb, go to IDLE.
  - In WAIT: go to DRAIN and keep cyc until wb_ack/wb_err/timeout. Discard the data, issue no instr_ack, then go to IDLE.
  - A new instr_req arriving during DRAIN waits until DRAIN ends.
- instr_addr change while req=1 is a protocol violation; behaviour is undefined. The bench must flag it.
- Simultaneous wb_ack and wb_err: wb_err wins.
- Timeout counter is 8+ bits, sized from WB_TIMEOUT, saturating; cleared on entry to WAIT.

Optional Feature:
IMEM_HIT_BUF_EN
- Defined: one-entry buffer of {valid, addr, data}, filled on each successful (non-err) response.
  - Aligned request in IDLE whose addr matches a valid entry: next cycle instr_ack=1 with the buffered data, no bus cycle.
  - fence_i=1 or rst clears valid. fence_i in the same cycle as a hit request forces a miss.
- Undefined: no buffer; fence_i unused; every request goes to the bus.

Decomposition:
- Package imem_pkg holds:
  - state enum {IDLE, REQ, WAIT, DRAIN}
  - the timeout-width function
  - the alignment-mask constant
- One sub-module, imem_wb_timeout: load/enable/saturate counter with an expired flag, parameterised by WB_TIMEOUT.

Test Plan:
- Zero-wait slave, req addr 0x10 (mem[4]=0x00500093) -> stb at cycle 1, instr_ack at cycle 3 with instr=0x00500093, instr_err=0.
- wb_stall held high 3 cycles on addr 0x18 -> stb and addr stable 4 cycles, exactly one accepted strobe, single ack with mem[6].
- Req 0x20, drop req one cycle after strobe accepted, slave acks 2 cycles later -> no instr_ack; next req 0x24 returns mem[9].
- Misaligned addr 0x0A -> instr_ack=1, instr_err=1 next cycle; wb_cyc never asserted.
- Slave never acks, WB_TIMEOUT=8 -> cyc drops and instr_ack+instr_err fire 8 cycles after acceptance; wb_err injected separately -> same error response.
- IMEM_HIT_BUF_EN: fetch 0x30 twice -> second ack one cycle after req, no wb_cyc. Pulse fence_i, fetch 0x30 again -> full bus cycle.
